// File: rtl/adc_serial_array.sv
// Serial ADC array reader: CH converters share sck/CS, each with its own sdo.
// Optional build macro ADC_AVG_EN averages 2^AVG_LOG2 frames per strobe.
// Ports: clk_100, reset (sync, active high), start (level), single (pulse),
//   sck/CS (registered, idle high), sdo[CH], busy, data_valid, adc_data.
module adc_serial_array #(
  parameter int CH         = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int LEAD_BITS  = 1,
  parameter int SCK_DIV    = 2,
  parameter int CS_HIGH    = 3,
  parameter int AVG_LOG2   = 2
) (
  input  logic                   clk_100,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   single,
  output logic                   sck,
  output logic                   CS,
  input  logic [CH-1:0]          sdo,
  output logic                   busy,
  output logic                   data_valid,
  output logic [CH*DATA_W-1:0]   adc_data
);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  localparam logic [15:0] CONV_LAST = 16'(CS_HIGH*2*SCK_DIV - 1);
  localparam logic [15:0] DIV_LAST  = 16'(SCK_DIV - 1);
  localparam logic [5:0]  BIT_LAST  = 6'(FRAME_BITS - 1);
  localparam logic [5:0]  BIT_LO    = 6'(LEAD_BITS);
  localparam logic [5:0]  BIT_HI    = 6'(LEAD_BITS + DATA_W);

  state_t              state;
  logic [15:0]         cnt;
  logic [5:0]          bit_cnt;
  logic [DATA_W-1:0]   shreg [CH];
  logic [CH*DATA_W-1:0] res;
  logic                capture;

  // Only the result window is shifted in; lead and trailing bits
  // are clocked past but never stored.
  assign capture = (bit_cnt >= BIT_LO) && (bit_cnt < BIT_HI);
  assign busy    = (state != IDLE);

  always_comb begin
    res = '0;
    for (int i = 0; i < CH; i++)
      res[i*DATA_W +: DATA_W] = shreg[i];
  end

`ifdef ADC_AVG_EN
  localparam int AW = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] F_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  logic [AW-1:0]         acc [CH];
  logic [AW-1:0]         sum [CH];
  logic [AVG_LOG2:0]     fcnt;
  logic [CH*DATA_W-1:0]  avg;

  always_comb begin
    avg = '0;
    for (int i = 0; i < CH; i++) begin
      sum[i] = acc[i] + AW'(shreg[i]);
      avg[i*DATA_W +: DATA_W] = DATA_W'(sum[i] >> AVG_LOG2);
    end
  end
`endif

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state      <= IDLE;
      sck        <= 1'b1;
      CS         <= 1'b1;
      data_valid <= 1'b0;
      adc_data   <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      for (int i = 0; i < CH; i++) shreg[i] <= '0;
`ifdef ADC_AVG_EN
      for (int i = 0; i < CH; i++) acc[i] <= '0;
      fcnt <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || single) begin
            state <= CONV;
            cnt   <= '0;
`ifdef ADC_AVG_EN
            for (int i = 0; i < CH; i++) acc[i] <= '0;
            fcnt <= '0;
`endif
          end
        end
        CONV: begin
          if (cnt == CONV_LAST) begin
            state   <= SHIFT;
            CS      <= 1'b0;
            sck     <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt <= '0;
            if (!sck) begin
              // Rising sck edge: sample every channel together.
              sck <= 1'b1;
              if (capture)
                for (int i = 0; i < CH; i++)
                  shreg[i] <= {shreg[i][DATA_W-2:0], sdo[i]};
            end else if (bit_cnt == BIT_LAST) begin
              state <= DONE;
              CS    <= 1'b1;
`ifdef ADC_AVG_EN
              if (fcnt == F_LAST) begin
                data_valid <= 1'b1;
                adc_data   <= avg;
                fcnt       <= '0;
                for (int i = 0; i < CH; i++) acc[i] <= '0;
              end else begin
                fcnt <= fcnt + 1'b1;
                for (int i = 0; i < CH; i++) acc[i] <= sum[i];
              end
`else
              data_valid <= 1'b1;
              adc_data   <= res;
`endif
            end else begin
              sck     <= 1'b0;
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        DONE: begin
          state <= start ? CONV : IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_array.sv
// Directed bench for adc_serial_array with a two-channel serial ADC model.
// Default parameters; ADC_AVG_EN selects the averaging sequence.
module tb_adc_serial_array;

  logic        clk_100 = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        single  = 1'b0;
  logic        sck;
  logic        CS;
  logic [1:0]  sdo     = 2'b00;
  logic        busy;
  logic        data_valid;
  logic [23:0] adc_data;

  adc_serial_array dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .start      (start),
    .single     (single),
    .sck        (sck),
    .CS         (CS),
    .sdo        (sdo),
    .busy       (busy),
    .data_valid (data_valid),
    .adc_data   (adc_data)
  );

  always #5 clk_100 = ~clk_100;

  logic [15:0] frame0 = 16'h55E0;
  logic [15:0] frame1 = 16'h2AA8;
  int          bidx   = 0;

  always @(posedge CS) bidx = 0;

  always @(negedge sck) begin
    if (bidx < 16) begin
      sdo[0] = frame0[15-bidx];
      sdo[1] = frame1[15-bidx];
    end
    bidx++;
  end

  int          tests = 0;
  int          fails = 0;
  int          cyc, cs_low, rises, dv_cnt, first_cs, cs_rise;
  int          dv_idx [8];
  logic [23:0] last_data;
  logic        sck_q, cs_q;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; cs_low = 0; rises = 0; dv_cnt = 0;
    first_cs = -1; cs_rise = 0;
    sck_q = sck; cs_q = CS;
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
    if (!CS) begin
      cs_low++;
      if (first_cs < 0) first_cs = cyc;
    end
    if (sck && !sck_q) rises++;
    if (CS && !cs_q) cs_rise++;
    sck_q = sck;
    cs_q  = CS;
    if (data_valid) begin
      if (dv_cnt < 8) dv_idx[dv_cnt] = cyc;
      dv_cnt++;
      last_data = adc_data;
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    clr();
    steps(3);
    check("rst_cs", CS, 1);
    check("rst_sck", sck, 1);
    check("rst_busy", busy, 0);
    check("rst_dv", data_valid, 0);
    check("rst_data", adc_data, 0);
    reset = 1'b0;
    steps(2);
    check("idle_busy", busy, 0);

`ifdef ADC_AVG_EN
    frame0 = 16'h0320;
    start  = 1'b1;
    clr();
    for (int k = 0; k < 400 && dv_cnt < 1; k++) begin
      step();
      if (cs_rise == 1) frame0 = 16'h0328;
      if (cs_rise == 2) frame0 = 16'h0330;
      if (cs_rise == 3) frame0 = 16'h0340;
    end
    start = 1'b0;
    check("avg_dv_cnt", dv_cnt, 1);
    check("avg_dv_idx", dv_idx[0], 307);
    check("avg_data", last_data, 24'h555065);
    for (int k = 0; k < 200 && busy; k++) step();
    check("avg_idle", busy, 0);
    check("avg_dv_total", dv_cnt, 1);
`else
    single = 1'b1;
    clr();
    step();
    single = 1'b0;
    for (int k = 0; k < 200 && busy; k++) step();
    check("s_idle", busy, 0);
    check("s_first_cs", first_cs, 12);
    check("s_cs_low", cs_low, 64);
    check("s_rises", rises, 16);
    check("s_dv_cnt", dv_cnt, 1);
    check("s_dv_idx", dv_idx[0], 76);
    check("s_idle_idx", cyc - 1, 77);
    check("s_data", last_data, 24'h555ABC);
    steps(20);
    check("s_no_more_dv", dv_cnt, 1);
    check("s_hold", adc_data, 24'h555ABC);

    start = 1'b1;
    clr();
    for (int k = 0; k < 400 && dv_cnt < 3; k++) step();
    check("c_dv_cnt", dv_cnt, 3);
    check("c_first", dv_idx[0], 76);
    check("c_per1", dv_idx[1] - dv_idx[0], 77);
    check("c_per2", dv_idx[2] - dv_idx[1], 77);
    check("c_data", last_data, 24'h555ABC);
    check("c_busy", busy, 1);

    for (int k = 0; k < 50 && CS; k++) step();
    check("d_cs_low", CS, 0);
    steps(10);
    start  = 1'b0;
    dv_cnt = 0;
    for (int k = 0; k < 200 && busy; k++) step();
    check("d_idle", busy, 0);
    steps(30);
    check("d_dv_cnt", dv_cnt, 1);
    check("d_cs", CS, 1);

    frame0 = 16'h800F;
    frame1 = 16'h601D;
    single = 1'b1;
    clr();
    step();
    single = 1'b0;
    for (int k = 0; k < 50 && CS; k++) step();
    check("r_cs_low", CS, 0);
    steps(19);
    reset = 1'b1;
    step();
    check("r_cs", CS, 1);
    check("r_sck", sck, 1);
    check("r_data", adc_data, 0);
    check("r_busy", busy, 0);
    check("r_dv", dv_cnt, 0);
    reset = 1'b0;
    steps(2);

    single = 1'b1;
    clr();
    step();
    single = 1'b0;
    steps(30);
    single = 1'b1;
    step();
    single = 1'b0;
    for (int k = 0; k < 200 && busy; k++) step();
    check("p_idle", busy, 0);
    check("p_dv_cnt", dv_cnt, 1);
    check("p_cs_low", cs_low, 64);
    check("p_data", last_data, 24'hC03001);
    steps(30);
    check("p_ignored", dv_cnt, 1);
    check("p_stay_idle", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
